// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts parallel words over valid/ready and
// sends each one MSB-first as a frame made of a SYNC header followed by the
// payload bits. Back-to-back frames leave no idle gap when valid is held high.
module serial_pattern_tx #(
    parameter int                  WIDTH    = 8,
    parameter int                  SYNC_LEN = 4,
    parameter logic [SYNC_LEN-1:0] SYNC     = 4'b1001,
    parameter logic                IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             frame_done
);

    // The counter must index the longer of header and payload. It is at least 1 bit wide.
    localparam int MAX_LEN = (SYNC_LEN > WIDTH) ? SYNC_LEN : WIDTH;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HDR  = 2'b01,
        S_DATA = 2'b10
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [WIDTH-1:0]     word, word_nxt;
    logic [SYNC_LEN-1:0]  sync_shift;

    // Header bit under the counter. It is taken from the MSB of the shifted pattern.
    assign sync_shift = SYNC << cnt;

    // State, bit counter and payload shift register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge and simulation order cannot
    // change the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            word  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            word  <= word_nxt;
        end
    end

    // Next-state, counter and word update, plus output decode. The outputs
    // depend only on registered state, except ready, which depends on no input.
    always_comb begin
        // NOTE: every signal gets a default before the case statement. This
        // means no path leaves a signal unassigned, and no latch is inferred.
        state_nxt  = state;
        cnt_nxt    = cnt;
        word_nxt   = word;
        bit_out    = IDLE_BIT;
        bit_valid  = 1'b0;
        frame_done = 1'b0;
        ready      = 1'b0;
        busy       = 1'b1;

        case (state)
            S_IDLE: begin
                busy  = 1'b0;
                ready = 1'b1;
                if (valid) begin
                    word_nxt  = data_in;
                    cnt_nxt   = '0;
                    state_nxt = S_HDR;
                end
            end

            S_HDR: begin
                bit_out   = sync_shift[SYNC_LEN-1];
                bit_valid = 1'b1;
                if (cnt == HDR_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_DATA;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_DATA: begin
                bit_out   = word[WIDTH-1];
                bit_valid = 1'b1;
                if (cnt == DATA_LAST) begin
                    frame_done = 1'b1;
                    ready      = 1'b1;
                    cnt_nxt    = '0;
                    if (valid) begin
                        // A new word chains straight into the next header.
                        word_nxt  = data_in;
                        state_nxt = S_HDR;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt  = cnt + CNT_W'(1);
                    word_nxt = word << 1;
                end
            end

            // NOTE: the unused encoding returns to IDLE. This keeps a
            // corrupted state register from locking up the line.
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx. It covers single frames, back-to-back
// frames, reset in the middle of a frame, input changes after acceptance, a
// receiver-side pattern detector, and a minimal 1-bit configuration.
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid;
    logic       ready, bit_out, bit_valid, busy, frame_done;

    logic [0:0] data1;
    logic       valid1;
    logic       ready1, bit_out1, bit_valid1, busy1, frame_done1;

    int         n_checks = 0;
    int         n_errors = 0;

    // Receiver-side 1001 detector, fed from the serial line.
    logic [3:0] det_sr;
    int         det_pos[$];

    always #5 clk = ~clk;

    serial_pattern_tx u_dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid     (valid),
        .ready     (ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .frame_done(frame_done)
    );

    serial_pattern_tx #(
        .WIDTH   (1),
        .SYNC_LEN(1),
        .SYNC    (1'b1),
        .IDLE_BIT(1'b0)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data1),
        .valid     (valid1),
        .ready     (ready1),
        .bit_out   (bit_out1),
        .bit_valid (bit_valid1),
        .busy      (busy1),
        .frame_done(frame_done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Send one word from IDLE and check all 12 frame cycles plus the idle cycle that follows.
    task automatic send_frame(input logic [7:0] word, input bit scramble, input string tag);
        logic [11:0] exp;
        exp = {4'b1001, word};
        check({tag, " ready_pre"}, ready, 1);
        data_in = word;
        valid   = 1'b1;
        tick;
        valid   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (scramble) data_in = 8'($urandom);
            check($sformatf("%s bit%0d", tag, i), bit_out, exp[11-i]);
            check($sformatf("%s bv%0d", tag, i), bit_valid, 1);
            check($sformatf("%s done%0d", tag, i), frame_done, (i == 11));
            check($sformatf("%s rdy%0d", tag, i), ready, (i == 11));
            if (bit_valid) begin
                det_sr = {det_sr[2:0], bit_out};
                if (det_sr == 4'b1001) det_pos.push_back(i);
            end
            tick;
        end
        check({tag, " idle_bv"}, bit_valid, 0);
        check({tag, " idle_bit"}, bit_out, 0);
        check({tag, " idle_rdy"}, ready, 1);
        check({tag, " idle_busy"}, busy, 0);
    endtask

    initial begin
        logic [23:0] exp2;
        int          hs;

        rst     = 1'b0;
        valid   = 1'b0;
        data_in = '0;
        valid1  = 1'b0;
        data1   = '0;
        det_sr  = '0;

        // Output state while reset is held.
        #12;
        check("rst bit_out", bit_out, 0);
        check("rst bit_valid", bit_valid, 0);
        check("rst busy", busy, 0);
        check("rst frame_done", frame_done, 0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        check("post_rst ready", ready, 1);

        // Test 1: a single frame.
        send_frame(8'hA5, 1'b0, "t1");

        // Test 2: back-to-back frames FF then 00, with valid held high.
        exp2    = {4'b1001, 8'hFF, 4'b1001, 8'h00};
        hs      = 0;
        data_in = 8'hFF;
        valid   = 1'b1;
        if (ready && valid) hs++;
        tick;
        data_in = 8'h00;
        for (int i = 0; i < 24; i++) begin
            check($sformatf("t2 bit%0d", i), bit_out, exp2[23-i]);
            check($sformatf("t2 bv%0d", i), bit_valid, 1);
            check($sformatf("t2 done%0d", i), frame_done, (i == 11 || i == 23));
            if (ready && valid) hs++;
            tick;
            if (hs == 2) valid = 1'b0;
        end
        check("t2 handshakes", hs, 2);
        check("t2 idle_bv", bit_valid, 0);

        // Test 3: asynchronous reset in DATA cycle 3 of word 3C.
        data_in = 8'h3C;
        valid   = 1'b1;
        tick;
        valid   = 1'b0;
        repeat (6) tick;
        check("t3 pre_rst bit", bit_out, 1);
        check("t3 pre_rst bv", bit_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t3 rst bv", bit_valid, 0);
        check("t3 rst busy", busy, 0);
        check("t3 rst bit", bit_out, 0);
        check("t3 rst done", frame_done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick;
        check("t3 release ready", ready, 1);
        check("t3 release bv", bit_valid, 0);
        send_frame(8'h81, 1'b0, "t3");

        // Test 4: data_in changes every cycle after acceptance.
        send_frame(8'h5A, 1'b1, "t4");

        // Test 5: word 12 through the detector. Hits are expected after the header and after the embedded 1001.
        det_sr = '0;
        det_pos.delete();
        send_frame(8'h12, 1'b0, "t5");
        check("t5 det_hits", det_pos.size(), 2);
        if (det_pos.size() == 2) begin
            check("t5 det_hdr_pos", det_pos[0], 3);
            check("t5 det_payload_pos", det_pos[1], 10);
        end

        // Test 6: WIDTH=1, SYNC_LEN=1, SYNC=1, data 0. The frame is "1 0".
        check("t6 ready", ready1, 1);
        data1  = 1'b0;
        valid1 = 1'b1;
        tick;
        valid1 = 1'b0;
        check("t6 c1 bit", bit_out1, 1);
        check("t6 c1 bv", bit_valid1, 1);
        check("t6 c1 done", frame_done1, 0);
        tick;
        check("t6 c2 bit", bit_out1, 0);
        check("t6 c2 bv", bit_valid1, 1);
        check("t6 c2 done", frame_done1, 1);
        tick;
        check("t6 idle bv", bit_valid1, 0);
        check("t6 idle busy", busy1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Upper bound on run time in case stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Transmit end of the serial single-bit pattern link. Accepts parallel words over a valid/ready handshake. Each word goes out MSB-first as one frame: the SYNC header (default 1 0 0 1) followed by the payload bits. The serial output feeds the link's serial pattern-detector input directly; the detector flags the header and downstream logic frames the payload.

Parameters:
WIDTH, 8, payload bits per frame (>= 1)
SYNC_LEN, 4, header length in bits (>= 1)
SYNC, 4'b1001, header pattern; sent MSB-first; width SYNC_LEN
IDLE_BIT, 1'b0, line level driven while no frame is in flight

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
data_in  input  WIDTH  payload word; sampled when valid && ready
valid  input  1  data_in holds a word to send
ready  output  1  block can accept a word this cycle
bit_out  output  1  serial line; one bit per clk
bit_valid  output  1  bit_out carries a header or payload bit this cycle
busy  output  1  frame in flight (state != IDLE)
frame_done  output  1  one-cycle pulse while the last payload bit is on bit_out

Behaviour:
- Reset (rst=0, async): state=IDLE, shift reg=0, bit counter=0. Outputs: bit_out=IDLE_BIT, bit_valid=0, busy=0, frame_done=0, ready=1 once rst releases. Reset mid-frame aborts the frame immediately and discards the word. No partial frame resumes.
- State register: states IDLE, HDR, DATA.
- bit_out, bit_valid and frame_done come straight from registers or state decode. There is no combinational path from valid or data_in to any output except ready.
- ready = (state==IDLE) || (state==DATA && cnt==WIDTH-1). ready does not depend on valid.
- IDLE:
  - bit_out=IDLE_BIT, bit_valid=0.
  - On valid && ready: latch data_in, cnt<=0, go to HDR.
- HDR:
  - bit_out=SYNC[SYNC_LEN-1-cnt], bit_valid=1.
  - cnt increments each cycle.
  - At cnt==SYNC_LEN-1: cnt<=0, go to DATA.
- DATA:
  - bit_out=word[WIDTH-1-cnt], bit_valid=1.
  - At cnt==WIDTH-1: frame_done=1.
  - If valid is also high in that cycle: latch the new data_in, cnt<=0, go to HDR (back-to-back frames with no idle gap).
  - Otherwise go to IDLE.
- Latency: word accepted at edge k; first header bit on bit_out in the cycle after edge k.
- Frame length: exactly SYNC_LEN+WIDTH cycles with bit_valid=1.
- The word register holds its value for the whole frame. data_in changes after acceptance have no effect.
- valid is ignored while ready=0. The upstream source must hold valid and data_in until it sees ready.
- Counter width: clog2(max(SYNC_LEN,WIDTH)), minimum 1 bit. cnt resets to 0 on every state entry and never wraps inside a state.
- Illegal or unused state encodings return to IDLE on the next edge.
- Payload may itself contain the SYNC pattern. No bit-stuffing; disambiguation is the receiver's job.

Test Plan:
1. Reset, then valid=1, data_in=8'hA5 for one accepted cycle -> bit_out for 12 cycles = 1 0 0 1 1 0 1 0 0 1 0 1, bit_valid=1 for those 12 cycles, frame_done=1 on cycle 12 only, ready=0 during cycles 1-11; then bit_out=0, bit_valid=0, ready=1.
2. valid held high with words 8'hFF then 8'h00 -> second header starts the cycle right after the last 1 of 8'hFF; stream is 1001 11111111 1001 00000000, 24 contiguous bit_valid cycles; exactly two ready&&valid handshakes.
3. Pulse rst=0 asynchronously in DATA cycle 3 of word 8'h3C -> same instant: bit_valid=0, busy=0, bit_out=0; after release ready=1, and a new word 8'h81 transmits a full clean frame.
4. Change data_in every cycle while a frame is in flight, valid=1 only in the accept cycle -> payload equals the word captured at acceptance.
5. Feed bit_out into the serial pattern detector, sending 8'h12 then idle -> detector output asserts once, following the header. Also asserts following payload bits "1001" (embedded pattern, documented behaviour).
6. Parameter sweep WIDTH=1, SYNC_LEN=1, SYNC=1'b1, data 1'b0 -> frame "1 0", two bit_valid cycles, frame_done on the second cycle.
